// File: rtl/neopixel_pkg.sv
// Shared types and default timing for the NeoPixel (WS2812) pixel encoder.
// Timing constants are in 50 MHz clocks.
package neopixel_pkg;

  localparam int unsigned PIX_W        = 24;
  localparam int unsigned DEF_T0H      = 20;
  localparam int unsigned DEF_T0L      = 42;
  localparam int unsigned DEF_T1H      = 40;
  localparam int unsigned DEF_T1L      = 22;
  localparam int unsigned DEF_TRESET   = 2600;

  typedef enum logic [2:0] {
    StIdle,
    StHigh,
    StLow,
    StWait,
    StLatch
  } state_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Brightness scaling: 16-bit product, keep the upper byte.
  function automatic logic [7:0] scale_byte(input logic [7:0] v, input logic [7:0] k);
    logic [15:0] p;
    p = 16'(v) * 16'(k);
    return p[15:8];
  endfunction

endpackage

// File: rtl/neopixel_phase_timer.sv
// Loadable down-counter shared by every encoder phase; o_zero marks the final phase clock.
module neopixel_phase_timer #(
  parameter int unsigned W = 12
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/neopixel_pixel_encoder.sv
// WS2812 serializer: GRB words in over valid/ready, single-wire NRZ out, latch after last pixel.
// Optional NEOPIXEL_BRIGHTNESS_EN adds a registered per-byte brightness scale stage.
module neopixel_pixel_encoder
  import neopixel_pkg::*;
#(
  parameter int unsigned T0H    = DEF_T0H,
  parameter int unsigned T0L    = DEF_T0L,
  parameter int unsigned T1H    = DEF_T1H,
  parameter int unsigned T1L    = DEF_T1L,
  parameter int unsigned TRESET = DEF_TRESET
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_last,
  input  logic             pix_valid,
  output logic             pix_ready,
`ifdef NEOPIXEL_BRIGHTNESS_EN
  input  logic [7:0]       brightness,
`endif
  output logic             data,
  output logic             busy,
  output logic             underrun
);

  localparam int unsigned TMAX  = max2(TRESET, max2(max2(T0H, T0L), max2(T1H, T1L)));
  localparam int unsigned TMR_W = $clog2(TMAX + 1);

  function automatic logic [TMR_W-1:0] f_high(input logic b);
    return b ? TMR_W'(T1H - 1) : TMR_W'(T0H - 1);
  endfunction

  function automatic logic [TMR_W-1:0] f_low(input logic b);
    return b ? TMR_W'(T1L - 1) : TMR_W'(T0L - 1);
  endfunction

  logic             r_rst_done;
  logic             r_hold_valid;
  logic             r_hold_last;
  logic [PIX_W-1:0] r_hold_word;

  state_e           r_state;
  logic [PIX_W-1:0] r_shift;
  logic             r_last;
  logic [4:0]       r_bit_cnt;
  logic             r_data;
  logic             r_underrun;

  logic             w_accept;
  logic             w_hold_pop;
  logic             w_src_valid;
  logic             w_src_last;
  logic [PIX_W-1:0] w_src_word;
  logic             w_load;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_zero;

  // r_rst_done keeps pix_ready low for the first cycle after reset release.
  assign pix_ready = r_rst_done & ~r_hold_valid;
  assign w_accept  = pix_valid & pix_ready;

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_rst_done   <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_last  <= 1'b0;
      r_hold_word  <= '0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_accept) begin
        r_hold_valid <= 1'b1;
        r_hold_word  <= pix_data;
        r_hold_last  <= pix_last;
      end else if (w_hold_pop) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

`ifdef NEOPIXEL_BRIGHTNESS_EN
  logic             r_scl_valid;
  logic             r_scl_last;
  logic [PIX_W-1:0] r_scl_word;

  // Hold advances into the scale stage whenever the stage is empty or being drained.
  assign w_hold_pop = r_hold_valid & (~r_scl_valid | w_load);

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_scl_valid <= 1'b0;
      r_scl_last  <= 1'b0;
      r_scl_word  <= '0;
    end else if (w_hold_pop) begin
      r_scl_valid <= 1'b1;
      r_scl_last  <= r_hold_last;
      r_scl_word  <= {scale_byte(r_hold_word[23:16], brightness),
                      scale_byte(r_hold_word[15:8], brightness),
                      scale_byte(r_hold_word[7:0], brightness)};
    end else if (w_load) begin
      r_scl_valid <= 1'b0;
    end
  end

  assign w_src_valid = r_scl_valid;
  assign w_src_last  = r_scl_last;
  assign w_src_word  = r_scl_word;
  assign busy        = (r_state != StIdle) | r_hold_valid | r_scl_valid;
`else
  assign w_hold_pop  = w_load;
  assign w_src_valid = r_hold_valid;
  assign w_src_last  = r_hold_last;
  assign w_src_word  = r_hold_word;
  assign busy        = (r_state != StIdle) | r_hold_valid;
`endif

  always_comb begin
    w_load     = 1'b0;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      StIdle, StWait: begin
        if (w_src_valid) begin
          w_load     = 1'b1;
          w_tmr_load = 1'b1;
          w_tmr_val  = f_high(w_src_word[PIX_W-1]);
        end
      end
      StHigh: begin
        if (w_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = f_low(r_shift[PIX_W-1]);
        end
      end
      StLow: begin
        if (w_zero) begin
          if (r_bit_cnt != 5'd0) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = f_high(r_shift[PIX_W-2]);
          end else if (r_last) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = TMR_W'(TRESET - 1);
          end else if (w_src_valid) begin
            w_load     = 1'b1;
            w_tmr_load = 1'b1;
            w_tmr_val  = f_high(w_src_word[PIX_W-1]);
          end
        end
      end
      default: ;
    endcase
  end

  // Data line is registered from the state, so it trails the FSM by one clock.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_last     <= 1'b0;
      r_bit_cnt  <= 5'd0;
      r_data     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_data     <= (r_state == StHigh);
      r_underrun <= 1'b0;
      if (w_load) begin
        r_shift   <= w_src_word;
        r_last    <= w_src_last;
        r_bit_cnt <= 5'(PIX_W - 1);
        r_state   <= StHigh;
      end else begin
        case (r_state)
          StHigh: begin
            if (w_zero) r_state <= StLow;
          end
          StLow: begin
            if (w_zero) begin
              if (r_bit_cnt != 5'd0) begin
                r_shift   <= {r_shift[PIX_W-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt - 5'd1;
                r_state   <= StHigh;
              end else if (r_last) begin
                r_state <= StLatch;
              end else begin
                r_underrun <= 1'b1;
                r_state    <= StWait;
              end
            end
          end
          StLatch: begin
            if (w_zero) r_state <= StIdle;
          end
          default: ;
        endcase
      end
    end
  end

  neopixel_phase_timer #(
    .W (TMR_W)
  ) u_timer (
    .i_clk      (CLOCK_50),
    .i_rst_n    (RESET_N),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_zero)
  );

  assign data     = r_data;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_neopixel_pixel_encoder.sv
// Self-checking bench for neopixel_pixel_encoder: queue-based line model plus directed timing checks.
module tb_neopixel_pixel_encoder;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_last = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready, data, busy, underrun;
`ifdef NEOPIXEL_BRIGHTNESS_EN
  logic [7:0]  brightness = 8'h80;
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  always #10 CLOCK_50 = ~CLOCK_50;

  neopixel_pixel_encoder dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
`ifdef NEOPIXEL_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .data       (data),
    .busy       (busy),
    .underrun   (underrun)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: the line is a queue of future levels, one per clock.
  typedef enum {KIdle, KWord, KLatch, KWait} kind_e;
  kind_e       m_kind = KIdle;
  bit          q[$];
  bit          m_hv, m_hl, m_sv, m_sl, m_rdy_ok, m_prev_lvl, m_cur_last;
  logic [23:0] m_hw, m_sw;
  bit          e_data, e_ready, e_busy, e_und;

  function automatic logic [23:0] sent_word(input logic [23:0] w);
`ifdef NEOPIXEL_BRIGHTNESS_EN
    logic [23:0] r;
    for (int i = 0; i < 3; i++) r[i*8 +: 8] = 8'((int'(w[i*8 +: 8]) * int'(brightness)) / 256);
    return r;
`else
    return w;
`endif
  endfunction

  task automatic push_word(input logic [23:0] w);
    for (int b = 23; b >= 0; b--) begin
      int h;
      h = w[b] ? 40 : 20;
      repeat (h) q.push_back(1'b1);
      repeat (62 - h) q.push_back(1'b0);
    end
  endtask

  initial begin : model
    bit acc, lvl, consume, s_valid, s_last, xfer;
    logic [23:0] s_word;
    forever begin
      @(posedge CLOCK_50);
      cyc++;
      if (!RESET_N) begin
        q.delete();
        m_kind = KIdle; m_hv = 0; m_sv = 0; m_rdy_ok = 0; m_prev_lvl = 0;
        e_data = 0; e_und = 0;
      end else begin
        acc = pix_valid && m_rdy_ok && !m_hv;
`ifdef NEOPIXEL_BRIGHTNESS_EN
        s_valid = m_sv; s_word = m_sw; s_last = m_sl;
`else
        s_valid = m_hv; s_word = m_hw; s_last = m_hl;
`endif
        consume = 0; e_und = 0;
        if (q.size() > 0) begin
          lvl = q.pop_front();
        end else if (m_kind == KWord && m_cur_last) begin
          repeat (2600) q.push_back(1'b0);
          m_kind = KLatch;
          lvl = q.pop_front();
        end else if (m_kind == KLatch) begin
          m_kind = KIdle;
          lvl = 0;
        end else if (s_valid) begin
          push_word(s_word);
          m_cur_last = s_last;
          m_kind = KWord;
          consume = 1;
          lvl = q.pop_front();
        end else begin
          if (m_kind == KWord) begin
            e_und = 1;
            m_kind = KWait;
          end
          lvl = 0;
        end
        e_data = m_prev_lvl;
        m_prev_lvl = lvl;
`ifdef NEOPIXEL_BRIGHTNESS_EN
        xfer = m_hv && (!m_sv || consume);
        if (consume) m_sv = 0;
        if (xfer) begin
          m_sv = 1; m_sl = m_hl; m_sw = sent_word(m_hw); m_hv = 0;
        end
`else
        xfer = 0;
        if (consume) m_hv = 0;
`endif
        if (acc) begin
          m_hv = 1; m_hw = pix_data; m_hl = pix_last;
        end
        m_rdy_ok = 1;
      end
      e_ready = m_rdy_ok && !m_hv;
      e_busy  = (m_kind != KIdle) || m_hv || m_sv;
    end
  end

  initial begin : compare
    forever begin
      @(negedge CLOCK_50);
      if (chk_en) begin
        check("data", {31'd0, data}, {31'd0, e_data});
        check("pix_ready", {31'd0, pix_ready}, {31'd0, e_ready});
        check("busy", {31'd0, busy}, {31'd0, e_busy});
        check("underrun", {31'd0, underrun}, {31'd0, e_und});
      end
    end
  end

  // Line monitor: high-run lengths, rise/fall cycles, underrun and busy-fall cycles.
  int rise_q[$], run_q[$], fall_q[$], und_q[$], bfall_q[$];
  initial begin : monitor
    bit pd = 0, pb = 0;
    int rs = 0;
    forever begin
      @(negedge CLOCK_50);
      if (chk_en) begin
        if (data === 1'b1 && !pd) begin rise_q.push_back(cyc); rs = cyc; end
        if (data !== 1'b1 && pd) begin run_q.push_back(cyc - rs); fall_q.push_back(cyc); end
        if (underrun === 1'b1) und_q.push_back(cyc);
        if (busy !== 1'b1 && pb) bfall_q.push_back(cyc);
        pd = (data === 1'b1);
        pb = (busy === 1'b1);
      end
    end
  end

  task automatic clr_mon();
    rise_q.delete(); run_q.delete(); fall_q.delete(); und_q.delete(); bfall_q.delete();
  endtask

  function automatic int qget(input int qq[$], input int i);
    if (i < qq.size()) return qq[i];
    return -1000000;
  endfunction

  function automatic logic [31:0] decode(input int first);
    logic [31:0] w;
    w = '0;
    if (run_q.size() < first + 24) return 32'hDEAD_0000;
    for (int i = 0; i < 24; i++) w[23-i] = (run_q[first+i] >= 30);
    return w;
  endfunction

  task automatic send(input logic [23:0] w, input logic l, output int acc_cyc);
    int n;
    pix_data = w; pix_last = l; pix_valid = 1'b1;
    n = 0;
    while (pix_ready !== 1'b1 && n < 8000) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (pix_ready !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: pix_ready low for %0d cycles, required 1", n);
    end
    acc_cyc = cyc + 1;
    @(negedge CLOCK_50);
  endtask

  task automatic drop();
    pix_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(m_kind == KIdle && !m_hv && !m_sv) && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= budget) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_idle: still active after %0d cycles, required idle", budget);
    end
    repeat (3) @(negedge CLOCK_50);
  endtask

  task automatic wait_runs(input int cnt, input int budget);
    int n;
    n = 0;
    while (run_q.size() < cnt && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (run_q.size() < cnt) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_runs: %0d runs seen, required %0d", run_q.size(), cnt);
    end
  endtask

  initial begin : watchdog
    repeat (98000) @(posedge CLOCK_50);
    $display("FAIL watchdog: bench exceeded its cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int a1, a2, a3, lo_len, n;
    logic [23:0] w;
    RESET_N = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    chk_en = 1;
    check("rst_data", {31'd0, data}, 32'd0);
    check("rst_ready", {31'd0, pix_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
    check("ready_after_release", {31'd0, pix_ready}, 32'd1);

    // 1: single last word
    clr_mon();
    send(24'h800001, 1'b1, a1); drop();
    wait_idle(8000);
`ifdef NEOPIXEL_BRIGHTNESS_EN
    check("t1_word", decode(0), 32'h0040_0000);
`else
    check("t1_word", decode(0), 32'h0080_0001);
    check("t1_first_run", qget(run_q, 0), 32'd40);
    check("t1_second_run", qget(run_q, 1), 32'd20);
`endif
    check("t1_runs", run_q.size(), 32'd24);
    check("t1_latency", qget(rise_q, 0) - a1, LAT);
    w = sent_word(24'h800001);
    lo_len = w[0] ? 22 : 42;
    check("t1_busy_fall", qget(bfall_q, 0) - qget(fall_q, 23), 2599 + lo_len);

    // 2: three words streamed with valid held
    clr_mon();
    send(24'h123456, 1'b0, a1);
    send(24'hFEDCBA, 1'b0, a2);
    send(24'h00FF00, 1'b1, a3); drop();
    wait_idle(12000);
    check("t2_runs", run_q.size(), 32'd72);
    check("t2_underruns", und_q.size(), 32'd0);
    check("t2_w0", decode(0), {8'd0, sent_word(24'h123456)});
    check("t2_w1", decode(24), {8'd0, sent_word(24'hFEDCBA)});
    check("t2_w2", decode(48), {8'd0, sent_word(24'h00FF00)});
    check("t2_span", qget(bfall_q, 0) - qget(rise_q, 0), 32'd7063);
    check("t2_accept_gap", a3 - a1 >= 1488 ? 1 : 0, 32'd1);

    // 3: underrun then late second word
    clr_mon();
    send(24'hC30000, 1'b0, a1); drop();
    repeat (3000) @(negedge CLOCK_50);
    send(24'h0000FF, 1'b1, a2); drop();
    wait_idle(8000);
    check("t3_underruns", und_q.size(), 32'd1);
    check("t3_und_pos", qget(und_q, 0) - qget(rise_q, 0), 32'd1487);
    check("t3_w2_latency", qget(rise_q, 24) - a2, LAT);
    check("t3_w0", decode(0), {8'd0, sent_word(24'hC30000)});
    check("t3_w1", decode(24), {8'd0, sent_word(24'h0000FF)});

    // 4: reset in the middle of bit 7's high phase
    clr_mon();
    send(24'hA5A5A5, 1'b1, a1); drop();
    n = 0;
    while (rise_q.size() < 17 && n < 2000) begin @(negedge CLOCK_50); n++; end
    check("t4_reached_bit7", rise_q.size(), 32'd17);
    repeat (5) @(negedge CLOCK_50);
    RESET_N = 1'b0;
    @(negedge CLOCK_50);
    check("t4_data", {31'd0, data}, 32'd0);
    check("t4_ready", {31'd0, pix_ready}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
    clr_mon();
    send(24'h3C0F81, 1'b1, a1); drop();
    wait_idle(8000);
    check("t4_runs", run_q.size(), 32'd24);
    check("t4_word", decode(0), {8'd0, sent_word(24'h3C0F81)});

    // 5: accept during the latch period
    clr_mon();
    send(24'hF0F0F1, 1'b1, a1); drop();
    wait_runs(24, 3000);
    repeat (1000) @(negedge CLOCK_50);
    send(24'h0F0F0F, 1'b1, a2); drop();
    check("t5_ready_held", {31'd0, pix_ready}, 32'd0);
    wait_idle(8000);
    w = sent_word(24'hF0F0F1);
    lo_len = w[0] ? 22 : 42;
    check("t5_restart", qget(rise_q, 24) - qget(fall_q, 23), 2601 + lo_len);
    check("t5_word", decode(24), {8'd0, sent_word(24'h0F0F0F)});
    check("t5_busy_falls", bfall_q.size(), 32'd1);

`ifdef NEOPIXEL_BRIGHTNESS_EN
    // 6: brightness scale
    clr_mon();
    brightness = 8'h80;
    send(24'hFF4002, 1'b1, a1); drop();
    wait_idle(8000);
    check("t6_scaled", decode(0), 32'h007F_2001);
`endif

    // Random stream checked cycle by cycle against the model
    for (int i = 0; i < 6; i++) begin
      int gap;
      logic l;
      l = (i == 5) || ($urandom_range(0, 2) == 0);
      send(24'($urandom), l, a1); drop();
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1500, 1800))
                                        : int'($urandom_range(0, 1200));
      repeat (gap) @(negedge CLOCK_50);
      if (i < 5 && $urandom_range(0, 7) == 0) begin
        RESET_N = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        RESET_N = 1'b1;
      end
    end
    wait_idle(12000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
